// File: rtl/bz_melody_seq.sv
// ---------------------------------------------------------------------------
// bz_melody_seq -- melody sequencer for the buzzer tone generator.
//
// Walks a song table held in an external combinational ROM, one note at a
// time. For each note it drives the tone generator's half-period count and
// enable for the programmed duration, then inserts a silent inter-note gap.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           1-cycle pulse, begin song at address 0 (only from IDLE)
//   stop            1-cycle pulse, abort to IDLE from any state (highest prio)
//   pause           level, freezes note/gap timing and mutes the tone
//   song_addr       song ROM address
//   song_data       {note[8:4], dur[3:0]}, valid the cycle after song_addr
//   pwm_parameter   half-period count to the tone generator
//   tone_en         tone generator enable
//   busy            high in every state except IDLE
//   done            1-cycle pulse when the song ends
//
// Build option
//   BZ_MELODY_LOOP_EN  when defined, the end of the song pulses done and
//                      restarts playback from address 0 until stop.
// ---------------------------------------------------------------------------
module bz_melody_seq #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned TICK_DIV  = 500_000,
   parameter int unsigned GAP_TICKS = 2,
   parameter int unsigned ADDR_W    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   output logic [ADDR_W-1:0] song_addr,
   input  logic [8:0]        song_data,
   output logic [19:0]       pwm_parameter,
   output logic              tone_en,
   output logic              busy,
   output logic              done
);

   localparam int unsigned PRE_W    = $clog2(TICK_DIV);
   localparam int unsigned GAP_CW   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam int unsigned TCNT_W   = (GAP_CW > 4) ? GAP_CW : 4;
   localparam int unsigned GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
   localparam int unsigned N_PITCH  = 21;

   localparam logic [4:0] NOTE_END       = 5'd31;
   localparam logic [4:0] NOTE_MAX_PITCH = 5'd21;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Third-octave base frequencies (C3..B3) in Hz.
   function automatic int unsigned base_hz(input int unsigned idx);
      case (idx)
         0:       base_hz = 131;
         1:       base_hz = 147;
         2:       base_hz = 165;
         3:       base_hz = 175;
         4:       base_hz = 196;
         5:       base_hz = 220;
         default: base_hz = 247;
      endcase
   endfunction

   // Half-period counts for codes 1..21, resolved at elaboration.
   function automatic logic [N_PITCH-1:0][19:0] build_pitch_tbl();
      logic [N_PITCH-1:0][19:0] tbl;
      int unsigned              f;
      for (int unsigned i = 0; i < N_PITCH; i++) begin
         f      = base_hz(i % 7) << (i / 7);
         tbl[i] = 20'(CLK_HZ / (2 * f) - 1);
      end
      return tbl;
   endfunction

   localparam logic [N_PITCH-1:0][19:0] PITCH_TBL = build_pitch_tbl();

   // State and datapath registers.
   logic [2:0]        state;
   logic [PRE_W-1:0]  pre;
   logic [TCNT_W-1:0] tcnt;
   logic [3:0]        dur_q;
   logic              pitch_q;
   logic              frz;

   // Next-state values.
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [19:0]       pwm_nxt;
   logic              tone_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic [PRE_W-1:0]  pre_nxt;
   logic [TCNT_W-1:0] tcnt_nxt;
   logic [3:0]        dur_nxt;
   logic              pitch_nxt;
   logic              frz_nxt;
   logic              adv_req;
   logic              end_req;

   // Song word decode.
   logic [4:0] note;
   logic [3:0] dur;
   logic       note_is_pitch;
   logic [4:0] pitch_idx;
   logic       tick;

   assign note          = song_data[8:4];
   assign dur           = song_data[3:0];
   assign note_is_pitch = (note != 5'd0) && (note <= NOTE_MAX_PITCH);
   assign pitch_idx     = note - 5'd1;
   assign tick          = (pre == PRE_W'(TICK_DIV - 1));

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         song_addr     <= '0;
         pwm_parameter <= '0;
         tone_en       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pre           <= '0;
         tcnt          <= '0;
         dur_q         <= '0;
         pitch_q       <= 1'b0;
         frz           <= 1'b0;
      end else begin
         state         <= state_nxt;
         song_addr     <= addr_nxt;
         pwm_parameter <= pwm_nxt;
         tone_en       <= tone_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         pre           <= pre_nxt;
         tcnt          <= tcnt_nxt;
         dur_q         <= dur_nxt;
         pitch_q       <= pitch_nxt;
         frz           <= frz_nxt;
      end
   end

   // Next-state and next-output logic.
   // frz is the registered pause: a cycle counts toward note/gap time only
   // when frz is low, which is exactly when tone_en reflects the pitch, so
   // pausing never shortens or lengthens the audible part of a note.
   always_comb begin
      state_nxt = state;
      addr_nxt  = song_addr;
      pwm_nxt   = pwm_parameter;
      tone_nxt  = tone_en;
      done_nxt  = 1'b0;
      pre_nxt   = pre;
      tcnt_nxt  = tcnt;
      dur_nxt   = dur_q;
      pitch_nxt = pitch_q;
      frz_nxt   = 1'b0;
      adv_req   = 1'b0;
      end_req   = 1'b0;

      case (state)
         S_IDLE: begin
            tone_nxt = 1'b0;
            if (start) begin
               addr_nxt  = '0;
               state_nxt = S_FETCH;
            end
         end

         S_FETCH: begin
            if (note == NOTE_END) begin
               end_req = 1'b1;
            end else begin
               // A rest keeps the previous pitch so the generator sees no glitch.
               if (note_is_pitch) begin
                  pwm_nxt = PITCH_TBL[pitch_idx];
               end
               tone_nxt  = note_is_pitch;
               pitch_nxt = note_is_pitch;
               dur_nxt   = dur;
               pre_nxt   = '0;
               tcnt_nxt  = '0;
               state_nxt = S_PLAY;
            end
         end

         S_PLAY: begin
            frz_nxt  = pause;
            tone_nxt = pitch_q & ~pause;
            if (!frz) begin
               if (tick) begin
                  pre_nxt = '0;
                  if (tcnt == TCNT_W'(dur_q)) begin
                     tone_nxt = 1'b0;
                     tcnt_nxt = '0;
                     if (GAP_TICKS > 0) begin
                        state_nxt = S_GAP;
                     end else begin
                        adv_req = 1'b1;
                     end
                  end else begin
                     tcnt_nxt = tcnt + TCNT_W'(1);
                  end
               end else begin
                  pre_nxt = pre + PRE_W'(1);
               end
            end
         end

         S_GAP: begin
            frz_nxt  = pause;
            tone_nxt = 1'b0;
            if (!frz) begin
               if (tick) begin
                  pre_nxt = '0;
                  if (tcnt == TCNT_W'(GAP_LAST)) begin
                     tcnt_nxt = '0;
                     adv_req  = 1'b1;
                  end else begin
                     tcnt_nxt = tcnt + TCNT_W'(1);
                  end
               end else begin
                  pre_nxt = pre + PRE_W'(1);
               end
            end
         end

         S_DONE: begin
            tone_nxt = 1'b0;
`ifdef BZ_MELODY_LOOP_EN
            addr_nxt  = '0;
            state_nxt = S_FETCH;
`else
            state_nxt = S_IDLE;
`endif
         end

         default: begin
            tone_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase

      // Running off the top of the address space ends the song; no wrap.
      if (adv_req) begin
         if (song_addr == '1) begin
            end_req = 1'b1;
         end else begin
            addr_nxt  = song_addr + ADDR_W'(1);
            state_nxt = S_FETCH;
         end
      end

      if (end_req) begin
         state_nxt = S_DONE;
         done_nxt  = 1'b1;
         tone_nxt  = 1'b0;
      end

      // Stop overrides everything, including a same-cycle start.
      if (stop) begin
         state_nxt = S_IDLE;
         done_nxt  = 1'b0;
         tone_nxt  = 1'b0;
         frz_nxt   = 1'b0;
      end

      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule
